// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte sources.
// Define UART_TX_SCHED_LOCK_EN to add req_last and hold the grant for multi-byte messages.
module uart_tx_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
`ifdef UART_TX_SCHED_LOCK_EN
  input  logic [NUM_REQ-1:0]   req_last,
`endif
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 trmt,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_CLR,
    S_WAIT_DONE
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ID_W-1:0]   r_ptr;
  logic [7:0]        r_tx_data;
  logic [ID_W-1:0]   r_grant_id;
  logic              r_busy;
  logic              r_trmt;

  logic              w_rr_any;
  logic [ID_W-1:0]   w_rr_win;
  logic              w_any;
  logic [ID_W-1:0]   w_win;
  logic [ID_W-1:0]   w_ptr_inc;
  logic [7:0]        w_win_data;
  logic              w_accept;

  // First valid requester at or after the pointer; scanning downwards lets the
  // nearest candidate overwrite farther ones.
  always_comb begin : p_rr
    int idx;
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_rr_any = 1'b0;
    w_rr_win = '0;
    idx      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        w_rr_any = 1'b1;
        w_rr_win = ID_W'(idx);
      end
    end
  end

`ifdef UART_TX_SCHED_LOCK_EN
  logic            r_locked;
  logic [ID_W-1:0] r_lock_id;
  logic            w_last;

  // While locked, only the owner of the open message may be granted.
  assign w_any  = r_locked ? req_valid[r_lock_id] : w_rr_any;
  assign w_win  = r_locked ? r_lock_id : w_rr_win;
  assign w_last = req_last[w_win];
`else
  assign w_any  = w_rr_any;
  assign w_win  = w_rr_win;
`endif

  assign w_ptr_inc  = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
  assign w_win_data = req_data[8*w_win +: 8];
  assign w_accept   = (r_state == S_IDLE) && w_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples values from before the edge, independent of block order.
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          // Gated by rst_n so no handshake is offered while held in reset.
          req_ready[w_win] = rst_n;
          w_state_nxt      = S_ISSUE;
        end
      end
      S_ISSUE:     w_state_nxt = S_WAIT_CLR;
      // A done flag still high from the previous byte must be seen low first.
      S_WAIT_CLR:  if (!tx_done) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (tx_done)  w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trmt     <= 1'b0;
      r_tx_data  <= 8'h00;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_ptr      <= '0;
    end else begin
      r_trmt <= w_accept;
      if (w_accept) begin
        r_tx_data  <= w_win_data;
        r_grant_id <= w_win;
        r_busy     <= 1'b1;
`ifndef UART_TX_SCHED_LOCK_EN
        r_ptr      <= w_ptr_inc;
`else
        if (w_last) r_ptr <= w_ptr_inc;
`endif
      end else if ((r_state == S_WAIT_DONE) && tx_done) begin
        r_busy <= 1'b0;
      end
    end
  end

`ifdef UART_TX_SCHED_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked  <= 1'b0;
      r_lock_id <= '0;
    end else if (w_accept) begin
      r_locked  <= !w_last;
      r_lock_id <= w_win;
    end
  end
`endif

  assign trmt     = r_trmt;
  assign tx_data  = r_tx_data;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));
  a_ready_idle_only: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state != S_IDLE) |-> (req_ready == '0));
  a_trmt_single: assert property (@(posedge clk) disable iff (!rst_n)
    trmt |=> !trmt);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: randomized sources and a UART stand-in,
// checked every cycle against a transaction-level model of the scheduler.
module tb_uart_tx_sched;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*8-1:0] req_data = '0;
`ifdef UART_TX_SCHED_LOCK_EN
  logic [N-1:0]   req_last = '0;
`endif
  logic [N-1:0]   req_ready;
  logic           trmt;
  logic [7:0]     tx_data;
  logic           tx_done;
  logic [1:0]     grant_id;
  logic           busy;

  int errors = 0;
  int checks = 0;

  uart_tx_sched #(.NUM_REQ(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
`ifdef UART_TX_SCHED_LOCK_EN
    .req_last (req_last),
`endif
    .req_ready(req_ready),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // UART stand-in: done stays high clr_delay cycles after trmt, then low for frame_len.
  int frame_len = 6;
  int clr_delay = 0;
  int age;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) age <= 0;
    else if (trmt) age <= 1;
    else if (age != 0) age <= (age >= clr_delay + frame_len) ? 0 : age + 1;
  end
  assign tx_done = !(age > clr_delay && age <= clr_delay + frame_len);

  // Sources, scoreboard and logs
  logic [7:0] src_q  [N][$];
  bit         src_l  [N][$];
  logic [7:0] exp_q  [N][$];
  int         gnt_log[$];
  logic [7:0] tx_log [$];
  int         trmt_cnt;
  int         gate_pct = 100;

  // Transaction-level model
  int         m_ptr, m_lock_id, m_t, m_gid;
  bit         m_locked, m_inflight, m_seen_low;
  logic [7:0] m_tx_data;

  task automatic model_reset();
    m_ptr = 0; m_lock_id = 0; m_t = 0; m_gid = 0;
    m_locked = 0; m_inflight = 0; m_seen_low = 0; m_tx_data = 8'h00;
  endtask

  task automatic clear_logs();
    gnt_log.delete(); tx_log.delete(); trmt_cnt = 0;
  endtask

  task automatic queue_byte(input int i, input logic [7:0] d, input bit last);
    src_q[i].push_back(d); src_l[i].push_back(last); exp_q[i].push_back(d);
  endtask

  function automatic int pick(input logic [N-1:0] v);
    if (m_locked) return v[m_lock_id] ? m_lock_id : -1;
    for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (src_q[i].size() != 0) && ($urandom_range(99) < gate_pct);
      req_data[8*i +: 8] = (src_q[i].size() != 0) ? src_q[i][0] : 8'($urandom);
`ifdef UART_TX_SCHED_LOCK_EN
      req_last[i]        = (src_q[i].size() != 0) ? src_l[i][0] : 1'b0;
`endif
    end
  endtask

  // Runs queued traffic to completion, checking every output every cycle.
  task automatic run_traffic(input int max_cycles);
    int c, w, g;
    logic [N-1:0] exp_ready, hs;
    c = 0;
    @(posedge clk); #1;
    drive_inputs();
    while (1) begin
      @(negedge clk);
      w = m_inflight ? -1 : pick(req_valid);
      exp_ready = '0;
      if (w >= 0) exp_ready[w] = 1'b1;
      checks += 5;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL req_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready);
      end
      if (trmt !== (m_inflight && m_t == 1)) begin
        errors++; $display("FAIL trmt c=%0d got=%b exp=%b", c, trmt, m_inflight && m_t == 1);
      end
      if (busy !== m_inflight) begin
        errors++; $display("FAIL busy c=%0d got=%b exp=%b", c, busy, m_inflight);
      end
      if (tx_data !== m_tx_data) begin
        errors++; $display("FAIL tx_data c=%0d got=%h exp=%h", c, tx_data, m_tx_data);
      end
      if (grant_id !== 2'(m_gid)) begin
        errors++; $display("FAIL grant_id c=%0d got=%0d exp=%0d", c, grant_id, m_gid);
      end
      if (trmt === 1'b1) begin
        trmt_cnt++;
        tx_log.push_back(tx_data);
        g = int'(grant_id);
        checks++;
        if ($isunknown(grant_id) || exp_q[g].size() == 0) begin
          errors++; $display("FAIL sb_unexpected c=%0d got id=%0d data=%h exp none", c, grant_id, tx_data);
        end else if (tx_data !== exp_q[g][0]) begin
          errors++; $display("FAIL sb_order c=%0d id=%0d got=%h exp=%h", c, g, tx_data, exp_q[g][0]);
          void'(exp_q[g].pop_front());
        end else begin
          void'(exp_q[g].pop_front());
        end
      end
      hs = req_ready & req_valid;
      if (w >= 0) begin
        m_inflight = 1; m_t = 1; m_seen_low = 0;
        m_tx_data = req_data[8*w +: 8]; m_gid = w;
        gnt_log.push_back(w);
`ifdef UART_TX_SCHED_LOCK_EN
        if (req_last[w]) begin m_locked = 0; m_ptr = (w + 1) % N; end
        else begin m_locked = 1; m_lock_id = w; end
`else
        m_ptr = (w + 1) % N;
`endif
      end else if (m_inflight) begin
        if (m_t >= 2) begin
          if (!m_seen_low) begin
            if (!tx_done) m_seen_low = 1;
          end else if (tx_done) begin
            m_inflight = 0;
          end
        end
        m_t++;
      end
      c++;
      if (all_empty() && !m_inflight) break;
      if (c >= max_cycles) begin
        checks++; errors++;
        $display("FAIL timeout after %0d cycles, exp traffic drained", c);
        break;
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        if (hs[i]) begin void'(src_q[i].pop_front()); void'(src_l[i].pop_front()); end
      drive_inputs();
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin src_q[i].delete(); src_l[i].delete(); end
    drive_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '1;
    req_data = 32'($urandom);
    #12;
    checks += 5;
    if (req_ready !== '0) begin errors++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    if (trmt !== 1'b0) begin errors++; $display("FAIL rst_trmt got=%b exp=0", trmt); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id got=%0d exp=0", grant_id); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    req_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_round_robin();
    clear_logs(); frame_len = 5; clr_delay = 0; gate_pct = 100;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) queue_byte(i, 8'(8'h10 + i), 1'b1);
    run_traffic(400);
    for (int k = 0; k < 5; k++) begin
      checks += 2;
      if (gnt_log.size() <= k || gnt_log[k] != k % N) begin
        errors++; $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, (gnt_log.size() > k) ? gnt_log[k] : -1, k % N);
      end
      if (tx_log.size() <= k || tx_log[k] !== 8'(8'h10 + k % N)) begin
        errors++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, (tx_log.size() > k) ? tx_log[k] : 8'hxx, 8'(8'h10 + k % N));
      end
    end
  endtask

  task automatic test_single();
    clear_logs(); frame_len = 8; clr_delay = 0;
    queue_byte(0, 8'hA5, 1'b1);
    run_traffic(100);
    checks += 2;
    if (trmt_cnt != 1) begin errors++; $display("FAIL single_trmt_count got=%0d exp=1", trmt_cnt); end
    if (tx_log.size() != 1 || tx_log[0] !== 8'hA5) begin
      errors++; $display("FAIL single_data got=%h exp=a5", (tx_log.size() != 0) ? tx_log[0] : 8'hxx);
    end
  endtask

  task automatic test_stale_done();
    clear_logs(); frame_len = 4; clr_delay = 4;
    queue_byte(2, 8'h5A, 1'b1);
    run_traffic(100);
    checks += 2;
    if (trmt_cnt != 1) begin errors++; $display("FAIL stale_trmt_count got=%0d exp=1", trmt_cnt); end
    if (gnt_log.size() != 1 || gnt_log[0] != 2) begin
      errors++; $display("FAIL stale_grant got=%0d exp=2", (gnt_log.size() != 0) ? gnt_log[0] : -1);
    end
    clr_delay = 0;
  endtask

  task automatic test_wrap_skip();
    clear_logs(); frame_len = 3;
    queue_byte(1, 8'h21, 1'b1);
    queue_byte(2, 8'h22, 1'b1);
    run_traffic(100);
    checks++;
    if (gnt_log.size() != 2 || gnt_log[0] != 1 || gnt_log[1] != 2) begin
      errors++; $display("FAIL wrap_skip got size=%0d first=%0d exp 1 then 2", gnt_log.size(), (gnt_log.size() != 0) ? gnt_log[0] : -1);
    end
  endtask

  task automatic test_random();
    int i;
    clear_logs();
    frame_len = $urandom_range(10, 1); clr_delay = $urandom_range(3); gate_pct = 60;
    for (int k = 0; k < 40; k++) begin
      i = $urandom_range(N - 1);
      queue_byte(i, 8'($urandom), 1'($urandom_range(1)));
    end
    for (int j = 0; j < N; j++)
      if (src_l[j].size() != 0) src_l[j][src_l[j].size() - 1] = 1'b1;
    run_traffic(6000);
    for (int j = 0; j < N; j++) begin
      checks++;
      if (exp_q[j].size() != 0) begin
        errors++; $display("FAIL random_lost req=%0d got %0d undelivered exp 0", j, exp_q[j].size());
        exp_q[j].delete();
      end
    end
    gate_pct = 100; clr_delay = 0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_logs(); frame_len = 10;
    queue_byte(1, 8'h3C, 1'b1);
    @(posedge clk); #1;
    drive_inputs();
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = req_ready[1] & req_valid[1];
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_accept got no grant exp req 1"); end
    @(posedge clk); #1;
    src_q[1].delete(); src_l[1].delete(); exp_q[1].delete();
    drive_inputs();
    repeat (5) @(posedge clk);
    #3;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    req_valid = 4'b0001;
    #1;
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
    if (trmt !== 1'b0) begin errors++; $display("FAIL mid_trmt got=%b exp=0", trmt); end
    if (req_ready !== '0) begin errors++; $display("FAIL mid_ready got=%b exp=0", req_ready); end
    if (grant_id !== 2'd0) begin errors++; $display("FAIL mid_grant_id got=%0d exp=0", grant_id); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx_data got=%h exp=00", tx_data); end
    req_valid = '0;
    #2 rst_n = 1'b1;
    model_reset();
    clear_logs();
    queue_byte(0, 8'h77, 1'b1);
    queue_byte(2, 8'h99, 1'b1);
    run_traffic(100);
    checks++;
    if (gnt_log.size() != 2 || gnt_log[0] != 0 || gnt_log[1] != 2) begin
      errors++; $display("FAIL mid_after_reset got first=%0d exp 0 then 2", (gnt_log.size() != 0) ? gnt_log[0] : -1);
    end
  endtask

`ifdef UART_TX_SCHED_LOCK_EN
  task automatic test_lock();
    int p;
    clear_logs(); frame_len = 3;
    for (int k = 0; k < 4; k++) queue_byte(0, 8'(8'h40 + k), 1'b1);
    queue_byte(2, 8'hB0, 1'b0);
    queue_byte(2, 8'hB1, 1'b0);
    queue_byte(2, 8'hB2, 1'b1);
    run_traffic(300);
    p = -1;
    foreach (gnt_log[k]) if (p < 0 && gnt_log[k] == 2) p = k;
    checks++;
    if (p < 0 || gnt_log.size() < p + 4 ||
        gnt_log[p+1] != 2 || gnt_log[p+2] != 2 || gnt_log[p+3] != 0) begin
      errors++; $display("FAIL lock_order first2_at=%0d size=%0d exp 2,2,2,0", p, gnt_log.size());
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired, exp bench to finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clear_logs();
    test_reset();
    test_round_robin();
    test_single();
    test_stale_done();
    test_wrap_skip();
    test_random();
    test_reset_mid();
`ifdef UART_TX_SCHED_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
